csr_counter_unit: RTL and testbench

- Parametrised counter/timer CSR block; successor to the machine CSR register file's fixed free-running cycle counter and timer compare.
- Holds mcycle, minstret and NUM_HPM hardware performance counters, each CNT_WIDTH wide.
- Implements mcountinhibit and mcounteren gating, split lo/hi CSR access, and a registered machine-timer compare.
- Sits beside the CSR register file. It shares the CSR read and writeback addresses and ORs its read data into the CSR read mux when csr_hit is high.

---
 rtl/csr_counter_unit.sv | 180 ++++++++++++++++++
 tb/tb_csr_counter_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_unit.sv
// Machine counter/timer CSR block: mcycle, minstret, mhpmcounters, inhibit/enable gating.
// Define CSR_COUNTER_TIMECMP_EN to add mtimecmp and the registered m_timer compare.
module csr_counter_unit #(
    parameter int NUM_HPM   = 4,
    parameter int CNT_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic [11:0]                         csr_address_r,
    input  logic [11:0]                         csr_address_wb,
    input  logic [31:0]                         csr_wb,
    input  logic                                csr_we,
    input  logic                                exception_pending,
    input  logic                                instr_retire,
    input  logic [(NUM_HPM>0?NUM_HPM:1)-1:0]    hpm_event,
    input  logic [1:0]                          current_mode,
    output logic [31:0]                         csr_data,
    output logic                                csr_hit,
    output logic                                csr_illegal,
    output logic                                m_timer
);

    localparam int NCNT = 3 + NUM_HPM;
    localparam int HW   = CNT_WIDTH - 32;
    localparam logic [63:0] ALL64 = (64'd1 << NCNT) - 64'd1;
    // Index 1 (mtime) lives elsewhere, so it is never implemented here.
    localparam logic [31:0] IMPL = ALL64[31:0] & ~32'h2;

    logic [CNT_WIDTH-1:0] cnt_q [NCNT];
    logic [CNT_WIDTH-1:0] cnt_d [NCNT];
    logic [31:0]          inhibit_q, inhibit_d;
    logic [31:0]          enable_q, enable_d;
    logic [NCNT-1:0]      ev;
    logic                 wr_ok;

    assign wr_ok = csr_we && !exception_pending;

    always_comb begin
        ev    = '0;
        ev[0] = 1'b1;
        ev[2] = instr_retire && !exception_pending;
        for (int i = 0; i < NUM_HPM; i++) begin
            ev[3+i] = hpm_event[i];
        end
    end

    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (!IMPL[k]) begin
                cnt_d[k] = '0;
            end else if (wr_ok && csr_address_wb == (12'hB00 | 12'(k))) begin
                cnt_d[k][31:0] = csr_wb;
            end else if (wr_ok && csr_address_wb == (12'hB80 | 12'(k))) begin
                cnt_d[k][CNT_WIDTH-1:32] = csr_wb[HW-1:0];
            end else if (ev[k] && !inhibit_q[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        inhibit_d = inhibit_q;
        enable_d  = enable_q;
        if (wr_ok && csr_address_wb == 12'h320) begin
            inhibit_d = csr_wb & IMPL;
        end
        if (wr_ok && csr_address_wb == 12'h306) begin
            enable_d = csr_wb & IMPL;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            inhibit_q <= '0;
            enable_q  <= '0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            inhibit_q <= inhibit_d;
            enable_q  <= enable_d;
        end
    end

`ifdef CSR_COUNTER_TIMECMP_EN
    logic [CNT_WIDTH-1:0] tcmp_q, tcmp_d;
    logic                 m_timer_q;
    logic [63:0]          tcmp64;

    assign tcmp64 = 64'(tcmp_q);

    always_comb begin
        tcmp_d = tcmp_q;
        if (wr_ok && csr_address_wb == 12'h7C0) begin
            tcmp_d[31:0] = csr_wb;
        end
        if (wr_ok && csr_address_wb == 12'h7C1) begin
            tcmp_d[CNT_WIDTH-1:32] = csr_wb[HW-1:0];
        end
    end

    // Compare uses pre-update mcycle and mtimecmp: one cycle of latency.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tcmp_q    <= '1;
            m_timer_q <= 1'b0;
        end else begin
            tcmp_q    <= tcmp_d;
            m_timer_q <= (cnt_q[0] >= tcmp_q);
        end
    end

    assign m_timer = m_timer_q;
`else
    assign m_timer = 1'b0;
`endif

    logic [4:0]  rd_idx;
    logic [63:0] rd_cnt;
    logic [31:0] rd_word;
    logic        rd_ctr, rd_m, rd_u;

    always_comb begin
        rd_idx = csr_address_r[4:0];
        rd_cnt = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (rd_idx == 5'(k)) begin
                rd_cnt = 64'(cnt_q[k]);
            end
        end
        rd_word = csr_address_r[7] ? rd_cnt[63:32] : rd_cnt[31:0];
        rd_ctr  = (csr_address_r[6:5] == 2'b00) && IMPL[rd_idx];
        rd_m    = rd_ctr && (csr_address_r[11:8] == 4'hB);
        rd_u    = rd_ctr && (csr_address_r[11:8] == 4'hC);
    end

    always_comb begin
        csr_data    = '0;
        csr_hit     = 1'b0;
        csr_illegal = 1'b0;
        unique case (1'b1)
            rd_m: begin
                csr_hit  = 1'b1;
                csr_data = rd_word;
            end
            rd_u: begin
                csr_hit = 1'b1;
                if (current_mode == 2'b11 || enable_q[rd_idx]) begin
                    csr_data = rd_word;
                end else begin
                    csr_illegal = 1'b1;
                end
            end
            (csr_address_r == 12'h306): begin
                csr_hit  = 1'b1;
                csr_data = enable_q;
            end
            (csr_address_r == 12'h320): begin
                csr_hit  = 1'b1;
                csr_data = inhibit_q;
            end
`ifdef CSR_COUNTER_TIMECMP_EN
            (csr_address_r == 12'h7C0): begin
                csr_hit  = 1'b1;
                csr_data = tcmp64[31:0];
            end
            (csr_address_r == 12'h7C1): begin
                csr_hit  = 1'b1;
                csr_data = tcmp64[63:32];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Bench for csr_counter_unit: directed plan steps plus a randomized phase
// checked against an arithmetic model of the counter CSRs.
module tb_csr_counter_unit;

    localparam int NH = 4;
    localparam int CW = 48;
`ifdef CSR_COUNTER_TIMECMP_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif
    localparam longint unsigned CM  = (64'd1 << CW) - 64'd1;
    localparam longint unsigned HIM = (64'd1 << (CW - 32)) - 64'd1;
    localparam logic [31:0] IMPLM = 32'h0000_007D;

    logic        clk;
    logic        nrst;
    logic [11:0] csr_address_r;
    logic [11:0] csr_address_wb;
    logic [31:0] csr_wb;
    logic        csr_we;
    logic        exception_pending;
    logic        instr_retire;
    logic [NH-1:0] hpm_event;
    logic [1:0]  current_mode;
    logic [31:0] csr_data;
    logic        csr_hit;
    logic        csr_illegal;
    logic        m_timer;

    csr_counter_unit #(.NUM_HPM(NH), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .nrst(nrst),
        .csr_address_r(csr_address_r),
        .csr_address_wb(csr_address_wb),
        .csr_wb(csr_wb),
        .csr_we(csr_we),
        .exception_pending(exception_pending),
        .instr_retire(instr_retire),
        .hpm_event(hpm_event),
        .current_mode(current_mode),
        .csr_data(csr_data),
        .csr_hit(csr_hit),
        .csr_illegal(csr_illegal),
        .m_timer(m_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint unsigned m_cnt [32];
    logic [31:0]     m_inh, m_en;
    longint unsigned m_tcmp;
    bit              m_mt;

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) m_cnt[k] = 0;
        m_inh  = '0;
        m_en   = '0;
        m_tcmp = CM;
        m_mt   = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model advances from the inputs held across it.
    task automatic tick();
        bit          wr, mt_n;
        logic [31:0] evv;
        wr   = csr_we && !exception_pending;
        mt_n = TEN && (m_cnt[0] >= m_tcmp);
        evv  = 32'(hpm_event) << 3;
        evv[0] = 1'b1;
        evv[2] = instr_retire && !exception_pending;
        for (int k = 0; k < 32; k++) begin
            if (IMPLM[k]) begin
                if (wr && csr_address_wb == 12'hB00 + 12'(k))
                    m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | 64'(csr_wb);
                else if (wr && csr_address_wb == 12'hB80 + 12'(k))
                    m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | ((64'(csr_wb) & HIM) << 32);
                else if (evv[k] && !m_inh[k])
                    m_cnt[k] = (m_cnt[k] + 1) & CM;
            end
        end
        if (wr && csr_address_wb == 12'h306) m_en = csr_wb & IMPLM;
        if (wr && csr_address_wb == 12'h320) m_inh = csr_wb & IMPLM;
        if (TEN && wr && csr_address_wb == 12'h7C0)
            m_tcmp = (m_tcmp & ~64'hFFFF_FFFF) | 64'(csr_wb);
        if (TEN && wr && csr_address_wb == 12'h7C1)
            m_tcmp = (m_tcmp & 64'hFFFF_FFFF) | ((64'(csr_wb) & HIM) << 32);
        @(posedge clk);
        #1;
        m_mt = mt_n;
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1;
        csr_address_wb = a;
        csr_wb = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input string tag);
        logic [31:0]     d;
        logic            h, il;
        int              k;
        longint unsigned v;
        csr_address_r = a;
        #1;
        d = '0; h = 1'b0; il = 1'b0;
        k = int'(a[4:0]);
        if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00 && IMPLM[k]) begin
            h = 1'b1;
            v = a[7] ? (m_cnt[k] >> 32) : (m_cnt[k] & 64'hFFFF_FFFF);
            if (a[11:8] == 4'hC && current_mode != 2'b11 && !m_en[k]) il = 1'b1;
            else d = v[31:0];
        end else if (a == 12'h306) begin
            h = 1'b1; d = m_en;
        end else if (a == 12'h320) begin
            h = 1'b1; d = m_inh;
        end else if (TEN && (a == 12'h7C0 || a == 12'h7C1)) begin
            h = 1'b1;
            v = a[0] ? (m_tcmp >> 32) : (m_tcmp & 64'hFFFF_FFFF);
            d = v[31:0];
        end
        chk({tag, "_data"}, csr_data, d);
        chk({tag, "_hit"}, 32'(csr_hit), 32'(h));
        chk({tag, "_ill"}, 32'(csr_illegal), 32'(il));
    endtask

    task automatic chk_mt(input string tag);
        chk(tag, 32'(m_timer), 32'(m_mt));
    endtask

    logic [11:0] alist [16];

    initial begin
        alist = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04,
                  12'hB06, 12'hB86, 12'hB07, 12'hB01, 12'hC00, 12'hC83,
                  12'h306, 12'h320, 12'h7C0, 12'h7C1};
        nrst = 1'b0;
        csr_address_r = 12'hB00;
        csr_address_wb = '0;
        csr_wb = '0;
        csr_we = 1'b0;
        exception_pending = 1'b0;
        instr_retire = 1'b0;
        hpm_event = '0;
        current_mode = 2'b11;
        model_reset();
        #2;
        rd(12'hB00, "rst_mcycle");
        rd(12'h320, "rst_inhibit");
        rd(12'h7C0, "rst_tcmp");
        chk("rst_mtimer", 32'(m_timer), 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Plan 1: ten edges after reset release
        repeat (10) tick();
        rd(12'hB00, "p1");
        chk("p1_const", csr_data, 32'd10);

        // Plan 2: write beats increment, carry into the upper half
        wr_csr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, "p2a");
        chk("p2a_const", csr_data, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00, "p2b_lo");
        chk("p2b_lo_const", csr_data, 32'd0);
        rd(12'hB80, "p2b_hi");
        chk("p2b_hi_const", csr_data, 32'd1);

        // Plan 3: mcounteren gating of user shadows
        current_mode = 2'b00;
        rd(12'hC02, "p3a");
        chk("p3a_ill_const", 32'(csr_illegal), 32'd1);
        wr_csr(12'h306, 32'h4);
        rd(12'hC02, "p3b");
        chk("p3b_ill_const", 32'(csr_illegal), 32'd0);
        rd(12'hC00, "p3c");
        current_mode = 2'b11;
        rd(12'h306, "p3d");
        chk("p3d_const", csr_data, 32'h4);

        // Plan 4: retire counting, exception suppression, inhibit
        for (int i = 0; i < 5; i++) begin
            instr_retire = 1'b1;
            exception_pending = (i == 1 || i == 3);
            tick();
        end
        instr_retire = 1'b0;
        exception_pending = 1'b0;
        wr_csr(12'h320, 32'h4);
        instr_retire = 1'b1;
        repeat (3) tick();
        instr_retire = 1'b0;
        rd(12'hB02, "p4");
        chk("p4_const", csr_data, 32'd3);
        exception_pending = 1'b1;
        wr_csr(12'hB02, 32'h55);
        exception_pending = 1'b0;
        rd(12'hB02, "p4_exc_wr");
        chk("p4_exc_const", csr_data, 32'd3);
        current_mode = 2'b01;
        rd(12'hC02, "p4_shadow");
        current_mode = 2'b11;

        // Plan 5: timer compare with one cycle of latency
        wr_csr(12'hB80, 32'd0);
        wr_csr(12'hB00, 32'd5);
        wr_csr(12'h7C1, 32'd0);
        wr_csr(12'h7C0, 32'd20);
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_mt("p5_loop");
        end
        rd(12'hB00, "p5_at20");
        chk("p5_at20_const", csr_data, 32'd20);
        chk("p5_mt0_const", 32'(m_timer), 32'd0);
        tick();
        chk("p5_mt1_const", 32'(m_timer), 32'(TEN));
        wr_csr(12'h7C0, 32'hFFFF_FFFF);
        wr_csr(12'h7C1, 32'hFFFF_FFFF);
        tick();
        chk("p5_clear_const", 32'(m_timer), 32'd0);
        rd(12'h7C1, "p5_tcmph");
        wr_csr(12'h7C1, 32'd0);
        wr_csr(12'h7C0, 32'd3);
        chk("p5_below_lat_const", 32'(m_timer), 32'd0);
        tick();
        chk("p5_below_const", 32'(m_timer), 32'(TEN));

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            instr_retire = 1'($urandom);
            exception_pending = ($urandom_range(0, 7) == 0);
            hpm_event = NH'($urandom);
            csr_we = ($urandom_range(0, 3) == 0);
            csr_address_wb = alist[$urandom_range(0, 15)];
            csr_wb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            tick();
            csr_we = 1'b0;
            chk_mt("rnd_mt");
            case ($urandom_range(0, 2))
                0: current_mode = 2'b00;
                1: current_mode = 2'b01;
                default: current_mode = 2'b11;
            endcase
            rd(alist[$urandom_range(0, 15)], "rnd");
            rd(12'hC00 | 12'($urandom_range(0, 7)), "rnd_sh");
        end
        instr_retire = 1'b0;
        exception_pending = 1'b0;
        hpm_event = '0;
        current_mode = 2'b11;

        // Full-width wrap of an hpm counter, hi half zero-extended
        wr_csr(12'h320, 32'd0);
        wr_csr(12'hB83, 32'hFFFF_FFFF);
        wr_csr(12'hB03, 32'hFFFF_FFFF);
        rd(12'hB83, "wrap_hi_pre");
        chk("wrap_hi_pre_const", csr_data, 32'h0000_FFFF);
        hpm_event = 4'b0001;
        tick();
        hpm_event = '0;
        rd(12'hB03, "wrap_lo");
        chk("wrap_lo_const", csr_data, 32'd0);
        rd(12'hB83, "wrap_hi");
        chk("wrap_hi_const", csr_data, 32'd0);

        // Plan 6: asynchronous reset mid-count
        for (int i = 0; i < 5; i++) begin
            hpm_event = NH'($urandom);
            tick();
        end
        hpm_event = 4'b0001;
        nrst = 1'b0;
        model_reset();
        rd(12'hB03, "p6_rst_hpm");
        rd(12'hB00, "p6_rst_cyc");
        rd(12'h320, "p6_rst_inh");
        chk("p6_rst_mt_const", 32'(m_timer), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            hpm_event = NH'(i & 1);
        end
        nrst = 1'b1;
        hpm_event = '0;
        tick();
        rd(12'hB03, "p6_idle");
        hpm_event = 4'b0001;
        tick();
        hpm_event = '0;
        rd(12'hB03, "p6_first");
        chk("p6_first_const", csr_data, 32'd1);
        rd(12'hB00, "p6_cyc");
        chk("p6_cyc_const", csr_data, 32'd2);
        chk_mt("p6_mt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
